snake_body: RTL
===============

SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter X_BITS, default 6, column index width.
REQ-002 Parameter Y_BITS, default 5, row index width.
REQ-003 Parameter GRID_W, default 40, playfield columns.
REQ-004 Parameter GRID_H, default 30, playfield rows.
REQ-005 Parameter MAX_LEN, default 64, segment storage depth; 2 <= MAX_LEN.
REQ-006 Parameter LEN_BITS, default 7, length width; 2**LEN_BITS > MAX_LEN.
REQ-007 Parameter INIT_LEN, default 3, length after reset; 1 <= INIT_LEN <= min(MAX_LEN, GRID_W/2).
REQ-008 clk  input  1  clock, all state updates on rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 tick  input  1  single-cycle game step strobe.
REQ-011 dir  input  2  requested heading: 00=up, 01=right, 10=down, 11=left.
REQ-012 grow  input  1  single-cycle pulse; snake gains one segment on the next accepted tick.
REQ-013 query_x / query_y  input  X_BITS / Y_BITS  cell to test for occupancy.
REQ-014 query_hit  output  1  registered: queried cell holds a live segment.
REQ-015 head_x / head_y  output  X_BITS / Y_BITS  current head cell (segment 0).
REQ-016 length  output  LEN_BITS  live segment count.
REQ-017 heading  output  2  heading applied on the last step.
REQ-018 dead  output  1  sticky game-over flag.

Function
REQ-019 Segments held in a shift array seg[0..MAX_LEN-1]; seg[0] is the head; indices >= length are don't-care and never reported.
REQ-020 State machine: RUN (steps on tick) and DEAD (ignores tick, grow, dir; positions frozen); RUN->DEAD on collision; DEAD exits only through reset.
REQ-021 Reversal rejection: on tick, if dir is the opposite of heading (XOR == 2'b10) heading is kept; otherwise heading <= dir; step uses the resulting heading.
REQ-022 Next head computed from seg[0] and resulting heading: up y-1, right x+1, down y+1, left x-1; without SNAKE_WALL_EN, wrap to GRID_W-1/GRID_H-1 at 0 and to 0 at GRID_W-1/GRID_H-1.
REQ-023 grow pulse sets grow_pending; cleared on the next RUN tick; grow coincident with tick is applied on that tick.
REQ-024 On RUN tick with no collision: seg[i] <= seg[i-1] for i>=1, seg[0] <= next head; if grow_pending and length < MAX_LEN, length <= length+1; at MAX_LEN grow is consumed and ignored.
REQ-025 Self-collision: next head equals any seg[i], i < length, excluding seg[length-1] when the step does not grow; on collision, dead <= 1 and no shift, length and heading unchanged.
REQ-026 Outputs head_x/head_y/length/heading/dead update on the same edge as the accepted tick (1-cycle latency from tick).
REQ-027 query_hit <= OR over i < length of (seg[i] == query); one-cycle latency; valid in both RUN and DEAD.

Reset
REQ-028 On reset: state RUN, dead 0, heading 01, grow_pending 0, length INIT_LEN, query_hit 0.
REQ-029 On reset: seg[i] = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN; reset mid-step discards any pending tick or grow.

Configuration
REQ-030 Macro SNAKE_WALL_EN: when defined, a step leaving the grid (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down) is a collision per REQ-025; when undefined, wrap per REQ-022.

Structure
REQ-031 Shared package holds direction encodings DIR_UP/RIGHT/DOWN/LEFT and state encodings RUN/DEAD.
REQ-032 One sub-module, snake_step: combinational next-head computation with wrap/wall flag output.

Verification
REQ-033 Reset defaults, 3 ticks dir=01 -> head (21,15),(22,15),(23,15); length 3; dead 0.
REQ-034 Head (39,y), dir=01, tick -> head (0,y); with SNAKE_WALL_EN -> dead 1, head stays (39,y).
REQ-035 Heading 01, dir=11, tick -> heading stays 01, head x+1.
REQ-036 grow pulse then tick -> length 4; grow at length MAX_LEN -> length unchanged.
REQ-037 Grow to 5, ticks with dir sequence 00,11,10 -> head enters own body, dead 1; further ticks leave head/length frozen.
REQ-038 Query tail cell at reset (18,15) -> query_hit 1 next cycle; query (0,0) -> 0.

Source files
------------

// File: rtl/snake_body_pkg.sv
// Shared encodings for the snake body datapath: headings and run state.
package snake_body_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_e;

    // Opposite headings differ only in bit 1.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_body_step.sv
// Next-head cell from the current head and a heading. The result always
// wraps at the playfield edge; off_grid flags that the step left the grid so
// the parent can treat it as a wall hit when walls are enabled.
module snake_step
    import snake_body_pkg::*;
#(
    parameter int X_BITS = 6,
    parameter int Y_BITS = 5,
    parameter int GRID_W = 40,
    parameter int GRID_H = 30
) (
    input  logic [X_BITS-1:0] cur_x,
    input  logic [Y_BITS-1:0] cur_y,
    input  logic [1:0]        dir,
    output logic [X_BITS-1:0] nxt_x,
    output logic [Y_BITS-1:0] nxt_y,
    output logic              off_grid
);

    // One cell in the heading direction, wrapping at the edges.
    always_comb begin
        nxt_x    = cur_x;
        nxt_y    = cur_y;
        off_grid = 1'b0;
        case (dir)
            DIR_UP: begin
                if (cur_y == '0) begin
                    nxt_y    = Y_BITS'(GRID_H - 1);
                    off_grid = 1'b1;
                end else begin
                    nxt_y = cur_y - Y_BITS'(1);
                end
            end
            DIR_RIGHT: begin
                if (cur_x == X_BITS'(GRID_W - 1)) begin
                    nxt_x    = '0;
                    off_grid = 1'b1;
                end else begin
                    nxt_x = cur_x + X_BITS'(1);
                end
            end
            DIR_DOWN: begin
                if (cur_y == Y_BITS'(GRID_H - 1)) begin
                    nxt_y    = '0;
                    off_grid = 1'b1;
                end else begin
                    nxt_y = cur_y + Y_BITS'(1);
                end
            end
            default: begin
                if (cur_x == '0) begin
                    nxt_x    = X_BITS'(GRID_W - 1);
                    off_grid = 1'b1;
                end else begin
                    nxt_x = cur_x - X_BITS'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_body.sv
// Snake body: segment shift array, heading/grow control, self and wall
// collision, and a registered cell-occupancy query.
// Optional build macro SNAKE_WALL_EN: leaving the grid kills the snake
// instead of wrapping to the opposite edge.
module snake_body
    import snake_body_pkg::*;
#(
    parameter int X_BITS   = 6,
    parameter int Y_BITS   = 5,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 64,
    parameter int LEN_BITS = 7,
    parameter int INIT_LEN = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [1:0]          dir,
    input  logic                grow,
    input  logic [X_BITS-1:0]   query_x,
    input  logic [Y_BITS-1:0]   query_y,
    output logic                query_hit,
    output logic [X_BITS-1:0]   head_x,
    output logic [Y_BITS-1:0]   head_y,
    output logic [LEN_BITS-1:0] length,
    output logic [1:0]          heading,
    output logic                dead
);

    state_e              state_q, state_d;
    logic [1:0]          heading_q, heading_d;
    logic                grow_pending_q, grow_pending_d;
    logic [LEN_BITS-1:0] length_q, length_d;
    logic                query_hit_q, query_hit_d;
    logic [X_BITS-1:0]   seg_x_q [MAX_LEN];
    logic [X_BITS-1:0]   seg_x_d [MAX_LEN];
    logic [Y_BITS-1:0]   seg_y_q [MAX_LEN];
    logic [Y_BITS-1:0]   seg_y_d [MAX_LEN];

    logic [1:0]          step_hd;
    logic [X_BITS-1:0]   nxt_x;
    logic [Y_BITS-1:0]   nxt_y;
    logic                off_grid;
    logic                grows;
    logic                self_hit;
    logic                collide;
    logic                step_en;

    assign step_hd = is_reverse(dir, heading_q) ? heading_q : dir;
    assign grows   = (grow_pending_q | grow) && (length_q < LEN_BITS'(MAX_LEN));
    assign step_en = (state_q == RUN) && tick;

    snake_step #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS),
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_step (
        .cur_x    (seg_x_q[0]),
        .cur_y    (seg_y_q[0]),
        .dir      (step_hd),
        .nxt_x    (nxt_x),
        .nxt_y    (nxt_y),
        .off_grid (off_grid)
    );

    // Self-collision; the tail cell is vacated this step unless the snake grows.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_BITS'(i) < length_q) &&
                !(LEN_BITS'(i) == length_q - LEN_BITS'(1) && !grows) &&
                seg_x_q[i] == nxt_x && seg_y_q[i] == nxt_y)
                self_hit = 1'b1;
        end
    end

`ifdef SNAKE_WALL_EN
    assign collide = self_hit | off_grid;
`else
    logic unused_off_grid;
    assign unused_off_grid = off_grid;
    assign collide         = self_hit;
`endif

    // State register plus all datapath flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            heading_q      <= DIR_RIGHT;
            grow_pending_q <= 1'b0;
            length_q       <= LEN_BITS'(INIT_LEN);
            query_hit_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? X_BITS'(GRID_W / 2 - i) : '0;
                seg_y_q[i] <= (i < INIT_LEN) ? Y_BITS'(GRID_H / 2) : '0;
            end
        end else begin
            state_q        <= state_d;
            heading_q      <= heading_d;
            grow_pending_q <= grow_pending_d;
            length_q       <= length_d;
            query_hit_q    <= query_hit_d;
            seg_x_q        <= seg_x_d;
            seg_y_q        <= seg_y_d;
        end
    end

    // Next state: a colliding step is the only way out of RUN.
    always_comb begin
        state_d = state_q;
        if (step_en && collide)
            state_d = DEAD;
    end

    // Outputs derived from the state register.
    always_comb begin
        dead = (state_q == DEAD);
    end

    // Step datapath: shift body, move head, extend length, track grow.
    always_comb begin
        heading_d      = heading_q;
        grow_pending_d = grow_pending_q;
        length_d       = length_q;
        seg_x_d        = seg_x_q;
        seg_y_d        = seg_y_q;
        if (state_q == RUN) begin
            if (grow)
                grow_pending_d = 1'b1;
            if (tick) begin
                grow_pending_d = 1'b0;
                if (!collide) begin
                    heading_d = step_hd;
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = nxt_x;
                    seg_y_d[0] = nxt_y;
                    if (grows)
                        length_d = length_q + LEN_BITS'(1);
                end
            end
        end
    end

    // Occupancy lookup over live segments, registered.
    always_comb begin
        query_hit_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_BITS'(i) < length_q && seg_x_q[i] == query_x && seg_y_q[i] == query_y)
                query_hit_d = 1'b1;
        end
    end

    assign query_hit = query_hit_q;
    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = length_q;
    assign heading   = heading_q;

endmodule
